uart_tx: RTL and testbench
==========================

# uart_tx

Parametrised UART transmitter: accepts words over a valid/ready handshake into a small internal FIFO and serialises them LSB-first as start / data / optional parity / stop frames on a registered `tx` line. Each bit is held for a programmable number of clock cycles. It succeeds the fixed 8-bit, one-bit-per-clock sender in the serial I/O path, feeding the board UART pin or a loopback receiver.

## Interface
- `DATA_W`, default 8: data bits per frame, legal 5..9.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, at least 2.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, default 4: input FIFO entries, power of two, at least 2.
- `PARITY_ODD`, default 0: parity sense, 0 = even, 1 = odd. Only used when parity is compiled in.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `in_valid` in 1: `in_data` is offered.
- `in_ready` out 1: FIFO not full. A word is accepted when `in_valid && in_ready` at a rising edge.
- `in_data` in `DATA_W`: word to send.
- `tx` out 1: serial line, idle high, registered.
- `busy` out 1: state is not IDLE, or the FIFO is not empty.
- `frame_done` out 1: one-cycle pulse at the end of each frame's last stop bit.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state type lives in `uart_pkg`.
- IDLE: `tx`=1. If the FIFO is not empty, pop the head into a shift register and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: shift out bit 0 first, `DATA_W` bits, each held `CLKS_PER_BIT` cycles. A bit counter runs 0..DATA_W-1.
  - Next state is PARITY if parity is compiled in, otherwise STOP.
- PARITY: send the XOR of the popped word, inverted when `PARITY_ODD`=1.
  - The parity value is computed at pop time from the latched word, not from `in_data`.
- STOP: `tx`=1 for `STOP_BITS*CLKS_PER_BIT` cycles. At the final cycle of the stop period, pulse `frame_done`.
  - If the FIFO is not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- The baud counter is reset on every state change. It does not free-run between frames.
- Frame length: `(1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT` cycles, where P is 1 if parity is compiled in, else 0.
- FIFO is a circular buffer with wrapping read/write pointers and an occupancy counter.
  - Full: `in_ready`=0, `in_valid` is ignored, and nothing is overwritten.
  - Push and pop in the same cycle when not full: level is unchanged.
  - Push into an empty FIFO while idle: the word is popped on the following edge.
- `in_data` is sampled only at the accepting edge. Changes at other times have no effect.

## Timing
- Reset values:
  - Outputs: `tx`=1, `busy`=0, `frame_done`=0, `fifo_level`=0, `in_ready`=1.
  - Internal: state IDLE, counters and pointers 0.
- Reset mid-frame: `tx` returns high asynchronously and the FIFO contents are discarded. The current frame is truncated and is not resumed.
- Latency: a word accepted at edge E into an idle, empty block is popped at edge E+1. `tx` falls at E+1.
- `frame_done` is high for exactly the one cycle before the next frame's START or IDLE entry.
- Back-to-back frames: the stop-bit high time is exactly `STOP_BITS*CLKS_PER_BIT` cycles, with no extra cycle.
- `busy` deasserts in the same cycle that the state enters IDLE with the FIFO empty.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity logic are built. The frame carries one parity bit per `PARITY_ODD`.
- Not defined: no parity state and no parity logic. Frames are start + data + stop, and `PARITY_ODD` is ignored.

## Structure
- `uart_pkg`: the state enum and a shared `parity_calc` function (even/odd over N bits). Both are reused by the companion receiver.
- Sub-module `uart_tx_fifo`: parametrised by width and depth, with push/pop/full/empty/level ports. The FSM, shift register and baud counter stay in `uart_tx`.

## Test plan
Settings: DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, parity on, even.
- Send 0x55: `tx` is 0,1,0,1,0,1,0,1,0,0,1, each bit 4 cycles, 44 cycles total. `frame_done` pulses once at cycle 44.
- Same settings with odd parity, send 0x00: parity bit = 1. With parity compiled out: 40-cycle frame, no parity bit.
- Push 5 words (0x01..0x05) back-to-back with DEPTH=4:
  - `in_ready` drops after the FIFO fills and the first word has been popped.
  - All 5 frames go out contiguously with no idle gap.
  - `busy` stays high throughout.
- STOP_BITS=2, send 0xA3: stop high for 8 cycles. Then `tx` stays 1 and `busy`=0.
- Assert `rst_n`=0 mid-DATA with 2 words queued:
  - `tx`=1 immediately, `fifo_level`=0, no `frame_done`.
  - After release, a new word 0x3C is sent correctly.
- DATA_W=5, send 0x1F with `in_data` toggled after acceptance: 0x1F is still sent (latched at the accepting edge).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state type and parity helper.
// Both are used by uart_tx and by the companion receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_MAX_W = 16;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_calc(input logic [PARITY_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Valid/ready word input of the UART transmitter.
// master drives words in; slave is the transmitter side.
interface uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular-buffer FIFO with wrapping pointers and an occupancy counter.
// Pushes when full and pops when empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered words sent LSB-first as start/data/[parity]/stop frames.
// Define UART_TX_PARITY_EN to build the parity bit (sense selected by PARITY_ODD).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_if.slave                    in_if,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(STOP_LEN);
  localparam int BIT_W    = $clog2(DATA_W);
  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_LEN - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  uart_state_e       state_r;
  uart_state_e       state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic [BIT_W-1:0]  bit_r;
  logic [BIT_W-1:0]  bit_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_s;
  logic              pop_s;
  logic              tx_s;
  logic              busy_s;
  logic              frame_done_s;
  logic              push_acc_s;
  logic [LVL_W-1:0]  level_next_s;
  logic [DATA_W-1:0] head_s;
  logic              full_s;
  logic              empty_s;
`ifdef UART_TX_PARITY_EN
  localparam logic ODD_SENSE = 1'(PARITY_ODD);
  logic              parity_r;
  logic              parity_s;
`endif

  uart_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_if.in_valid),
    .push_data (in_if.in_data),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (fifo_level)
  );

  assign in_if.in_ready = !full_s;
  assign push_acc_s     = in_if.in_valid && !full_s;
  assign level_next_s   = fifo_level + LVL_W'(push_acc_s) - LVL_W'(pop_s);

  // Next-state, counters and shift register; the baud counter restarts on every state change.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_W'(1);
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = head_s;
`ifdef UART_TX_PARITY_EN
          parity_s = parity_calc(PARITY_MAX_W'(head_s), ODD_SENSE);
`endif
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == BIT_END) begin
          cnt_s   = {CNT_W{1'b0}};
          bit_s   = {BIT_W{1'b0}};
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (cnt_r == BIT_END) begin
          cnt_s = {CNT_W{1'b0}};
          if (bit_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s   = bit_r + BIT_W'(1);
            shift_s = shift_r >> 1;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_r == BIT_END) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (cnt_r == STOP_END) begin
          cnt_s = {CNT_W{1'b0}};
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_s = head_s;
`ifdef UART_TX_PARITY_EN
            parity_s = parity_calc(PARITY_MAX_W'(head_s), ODD_SENSE);
`endif
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so they register in step with it.
  always_comb begin
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_s = parity_s;
`endif
      default: tx_s = 1'b1;
    endcase
    frame_done_s = (state_s == STOP) && (cnt_s == STOP_END);
    busy_s       = (state_s != IDLE) || (level_next_s != {LVL_W{1'b0}});
  end

  // State, datapath and registered outputs; reset drives the line idle-high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      bit_r      <= {BIT_W{1'b0}};
      shift_r    <= {DATA_W{1'b0}};
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_r      <= bit_s;
      shift_r    <= shift_s;
      tx         <= tx_s;
      busy       <= busy_s;
      frame_done <= frame_done_s;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the word latched at pop time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity_s;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (8-bit/1-stop/even and 5-bit/2-stop/odd) checked
// against a frame-level reference model built from the serial format rules.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB   = 4;
  localparam int LEN_A = (1 + 8 + P + 1) * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_W(8)) if_a ();
  uart_tx_if #(.DATA_W(5)) if_b ();

  logic       tx_a, busy_a, fd_a, tx_b, busy_b, fd_b;
  logic [2:0] lvl_a, lvl_b;

  uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_if(if_a), .tx(tx_a), .busy(busy_a),
    .frame_done(fd_a), .fifo_level(lvl_a));

  uart_tx #(.DATA_W(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_if(if_b), .tx(tx_b), .busy(busy_b),
    .frame_done(fd_b), .fifo_level(lvl_b));

  int checks = 0;
  int errors = 0;

  bit   exp_tx[$];
  bit   exp_fd[$];
  logic obs_tx[$];
  logic obs_fd[$];
  logic obs_busy[$];
  logic rdy_last, rdy_after;
  logic [2:0] lvl_after;
  int unsigned wq[$];

  // Reference frame: start 0, data LSB-first, optional parity, stop 1s; each bit CPB cycles.
  function automatic void add_frame(input int unsigned w, input int sel);
    int dw   = (sel == 0) ? 8 : 5;
    int nst  = (sel == 0) ? 1 : 2;
    int odd  = (sel == 0) ? 0 : 1;
    int unsigned m = w & ((32'd1 << dw) - 32'd1);
    bit b[$];
    b.push_back(1'b0);
    for (int i = 0; i < dw; i++) b.push_back(bit'((m >> i) & 32'd1));
    if (P == 1) b.push_back(bit'(($countones(m) + odd) % 2));
    for (int i = 0; i < nst; i++) b.push_back(1'b1);
    foreach (b[i]) for (int c = 0; c < CPB; c++) begin
      exp_tx.push_back(b[i]);
      exp_fd.push_back(1'b0);
    end
    exp_fd[exp_fd.size() - 1] = 1'b1;
  endfunction

  function automatic int tx_diff();
    foreach (exp_tx[i]) if (obs_tx[i] !== logic'(exp_tx[i])) return i;
    return -1;
  endfunction

  function automatic int fd_diff();
    foreach (exp_fd[i]) if (obs_fd[i] !== logic'(exp_fd[i])) return i;
    return -1;
  endfunction

  function automatic int busy_gap();
    for (int i = 1; i < obs_busy.size(); i++) if (obs_busy[i] !== 1'b1) return i;
    return -1;
  endfunction

  task automatic drive(input int sel, input logic v, input int unsigned d);
    if (sel == 0) begin
      if_a.in_valid = v;
      if_a.in_data  = d[7:0];
    end else begin
      if_b.in_valid = v;
      if_b.in_data  = d[4:0];
    end
  endtask

  task automatic collect(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_tx.push_back(sel == 0 ? tx_a : tx_b);
      obs_fd.push_back(sel == 0 ? fd_a : fd_b);
      obs_busy.push_back(sel == 0 ? busy_a : busy_b);
    end
  endtask

  // Pushes words on consecutive edges, then toggles in_data; collects the whole serial stream.
  task automatic run_burst(input int sel, input int unsigned words[$]);
    exp_tx.delete(); exp_fd.delete();
    obs_tx.delete(); obs_fd.delete(); obs_busy.delete();
    repeat (2) begin
      exp_tx.push_back(1'b1);
      exp_fd.push_back(1'b0);
    end
    foreach (words[k]) add_frame(words[k], sel);
    @(posedge clk); #1;
    fork
      collect(sel, exp_tx.size());
      begin
        foreach (words[k]) begin
          drive(sel, 1'b1, words[k]);
          rdy_last = (sel == 0) ? if_a.in_ready : if_b.in_ready;
          @(posedge clk); #1;
        end
        rdy_after = (sel == 0) ? if_a.in_ready : if_b.in_ready;
        lvl_after = (sel == 0) ? lvl_a : lvl_b;
        drive(sel, 1'b0, ~words[words.size() - 1]);
      end
    join
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({tx_a, busy_a, fd_a, if_a.in_ready, lvl_a} !== 7'b1_0_0_1_000) begin
      errors++;
      $display("FAIL reset_a: tx/busy/fd/rdy/lvl=%b required 1001000", {tx_a, busy_a, fd_a, if_a.in_ready, lvl_a});
    end
    checks++;
    if ({tx_b, busy_b, fd_b, if_b.in_ready, lvl_b} !== 7'b1_0_0_1_000) begin
      errors++;
      $display("FAIL reset_b: tx/busy/fd/rdy/lvl=%b required 1001000", {tx_b, busy_b, fd_b, if_b.in_ready, lvl_b});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame_55();
    int d;
    wq = {32'h55};
    run_burst(0, wq);
    d = tx_diff(); checks++;
    if (d >= 0) begin errors++; $display("FAIL frame55_tx: cycle %0d tx=%b required %b", d, obs_tx[d], exp_tx[d]); end
    d = fd_diff(); checks++;
    if (d >= 0) begin errors++; $display("FAIL frame55_done: cycle %0d frame_done=%b required %b", d, obs_fd[d], exp_fd[d]); end
    d = busy_gap(); checks++;
    if (d >= 0) begin errors++; $display("FAIL frame55_busy: cycle %0d busy=%b required 1", d, obs_busy[d]); end
    @(negedge clk); checks++;
    if ({tx_a, busy_a} !== 2'b10) begin errors++; $display("FAIL frame55_idle: tx,busy=%b required 10", {tx_a, busy_a}); end
  endtask

  task automatic test_random_frames();
    int d;
    for (int r = 0; r < 6; r++) begin
      int sel = (r < 4) ? 0 : 1;
      int n   = $urandom_range(4, 1);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back($urandom_range(255, 0));
      run_burst(sel, wq);
      d = tx_diff(); checks++;
      if (d >= 0) begin errors++; $display("FAIL random_tx[%0d]: cycle %0d tx=%b required %b", r, d, obs_tx[d], exp_tx[d]); end
      d = fd_diff(); checks++;
      if (d >= 0) begin errors++; $display("FAIL random_done[%0d]: cycle %0d frame_done=%b required %b", r, d, obs_fd[d], exp_fd[d]); end
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    wq = {32'h01, 32'h02, 32'h03, 32'h04, 32'h05};
    run_burst(0, wq);
    d = tx_diff(); checks++;
    if (d >= 0) begin errors++; $display("FAIL b2b_tx: cycle %0d tx=%b required %b", d, obs_tx[d], exp_tx[d]); end
    d = fd_diff(); checks++;
    if (d >= 0) begin errors++; $display("FAIL b2b_done: cycle %0d frame_done=%b required %b", d, obs_fd[d], exp_fd[d]); end
    d = busy_gap(); checks++;
    if (d >= 0) begin errors++; $display("FAIL b2b_busy: cycle %0d busy=%b required 1", d, obs_busy[d]); end
    checks++;
    if (rdy_last !== 1'b1) begin errors++; $display("FAIL b2b_rdy_before_fill: in_ready=%b required 1", rdy_last); end
    checks++;
    if (rdy_after !== 1'b0) begin errors++; $display("FAIL b2b_rdy_full: in_ready=%b required 0", rdy_after); end
    checks++;
    if (lvl_after !== 3'd4) begin errors++; $display("FAIL b2b_level: fifo_level=%0d required 4", lvl_after); end
    @(negedge clk);
  endtask

  task automatic test_stop2_w5();
    int d;
    int bad = 0;
    wq = {32'h1F};
    run_burst(1, wq);
    d = tx_diff(); checks++;
    if (d >= 0) begin errors++; $display("FAIL w5_tx: cycle %0d tx=%b required %b", d, obs_tx[d], exp_tx[d]); end
    d = fd_diff(); checks++;
    if (d >= 0) begin errors++; $display("FAIL w5_done: cycle %0d frame_done=%b required %b", d, obs_fd[d], exp_fd[d]); end
    repeat (10) begin
      @(negedge clk);
      if ({tx_b, busy_b} !== 2'b10) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL w5_idle: %0d cycles not idle (tx=1,busy=0) required 0", bad); end
    wq = {32'h00};
    run_burst(1, wq);
    d = tx_diff(); checks++;
    if (d >= 0) begin errors++; $display("FAIL w5_zero_tx: cycle %0d tx=%b required %b", d, obs_tx[d], exp_tx[d]); end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    int bad = 0;
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h00); @(posedge clk); #1;
    drive(0, 1'b1, 32'h5A); @(posedge clk); #1;
    drive(0, 1'b1, 32'hC3); @(posedge clk); #1;
    drive(0, 1'b0, 32'h00);
    repeat (6) @(negedge clk);
    checks++;
    if ({tx_a, lvl_a} !== 4'b0_010) begin errors++; $display("FAIL midframe_pre: tx,lvl=%b required 0010", {tx_a, lvl_a}); end
    #2 rst_n = 1'b0;
    #1 checks++;
    if ({tx_a, busy_a, fd_a, lvl_a, if_a.in_ready} !== 7'b1_0_0_000_1) begin
      errors++;
      $display("FAIL midframe_reset: tx/busy/fd/lvl/rdy=%b required 1000001", {tx_a, busy_a, fd_a, lvl_a, if_a.in_ready});
    end
    repeat (3) begin
      @(negedge clk);
      if (fd_a !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (2 * LEN_A) begin
      @(negedge clk);
      if ({tx_a, busy_a, fd_a} !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midframe_resume: %0d cycles with activity required 0", bad); end
    wq = {32'h3C};
    run_burst(0, wq);
    d = tx_diff(); checks++;
    if (d >= 0) begin errors++; $display("FAIL post_reset_tx: cycle %0d tx=%b required %b", d, obs_tx[d], exp_tx[d]); end
    d = fd_diff(); checks++;
    if (d >= 0) begin errors++; $display("FAIL post_reset_done: cycle %0d frame_done=%b required %b", d, obs_fd[d], exp_fd[d]); end
  endtask

  initial begin
    if_a.in_valid = 1'b0; if_a.in_data = 8'h00;
    if_b.in_valid = 1'b0; if_b.in_data = 5'h00;
    repeat (2) @(posedge clk);
    test_reset();
    test_frame_55();
    test_random_frames();
    test_back_to_back();
    test_stop2_w5();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
